// File: rtl/button_conditioner_ice.sv
// rtl/button_conditioner_ice.sv - three-channel push-button synchroniser, debouncer, press and long-hold detector
module button_conditioner_ice #(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int HOLD_CYCLES     = 1000000,
  parameter int CNT_W           = 14,
  parameter int HOLD_W          = 20
) (
  input  logic       clk_in,
  input  logic       res,
  input  logic       ena,
  input  logic [2:0] i_buttons,
  output logic [2:0] o_level,
  output logic [2:0] o_press,
  output logic [2:0] o_hold
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RISE_CHK = 2'd1,
    HIGH     = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  // Debounce counter value on the last sample of a qualifying run.
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Hold counter saturation point and the value one step before it.
  localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [2:0] s1_q;
  logic [2:0] s2_q;

  // Two-flop synchroniser; runs regardless of ena so the frozen FSMs resume on fresh data.
  always_ff @(posedge clk_in or posedge res) begin
    if (res) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_buttons;
      s2_q <= s1_q;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [HOLD_W-1:0] hcnt_q;
    logic [HOLD_W-1:0] hcnt_d;
    logic              level_q;
    logic              level_d;
    logic              press_q;
    logic              press_d;
    logic              hold_q;
    logic              hold_d;

    logic              btn;
    logic              deb_done;
    logic [HOLD_W-1:0] hcnt_step;
    logic              hold_fire;

    assign btn       = s2_q[g];
    assign deb_done  = (cnt_q == DEB_LAST);
    // Hold counter advances until it reaches HOLD_CYCLES and then sticks there.
    assign hcnt_step = (hcnt_q != HOLD_TOP) ? (hcnt_q + HOLD_W'(1)) : hcnt_q;
    // Fires only on the single step into saturation, so it cannot repeat while held.
    assign hold_fire = (hcnt_q == HOLD_LAST);

    // State and registered outputs; reset returns the channel to IDLE at once.
    always_ff @(posedge clk_in or posedge res) begin
      if (res) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        hold_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        hold_q  <= hold_d;
      end
    end

    // Next-state: a level change is accepted only after a full run of stable samples.
    always_comb begin
      state_d = state_q;
      if (ena) begin
        case (state_q)
          IDLE:     if (btn) state_d = RISE_CHK;
          RISE_CHK: begin
            if (!btn)          state_d = IDLE;
            else if (deb_done) state_d = HIGH;
          end
          HIGH:     if (!btn) state_d = FALL_CHK;
          FALL_CHK: begin
            if (btn)           state_d = HIGH;
            else if (deb_done) state_d = IDLE;
          end
          default:  state_d = IDLE;
        endcase
      end
    end

    // Counters and outputs; with ena low everything holds and the pulses are suppressed.
    always_comb begin
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      hold_d  = 1'b0;
      if (ena) begin
        case (state_q)
          IDLE: begin
            cnt_d = btn ? CNT_W'(1) : '0;
          end
          RISE_CHK: begin
            if (!btn) begin
              cnt_d = '0;
            end else if (deb_done) begin
              cnt_d   = '0;
              hcnt_d  = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          HIGH: begin
            cnt_d  = btn ? '0 : CNT_W'(1);
            hcnt_d = hcnt_step;
            hold_d = hold_fire;
          end
          FALL_CHK: begin
            if (btn) begin
              cnt_d  = '0;
              hcnt_d = hcnt_step;
              hold_d = hold_fire;
            end else if (deb_done) begin
              // Release accepted: no hold pulse on the same edge the level drops.
              cnt_d   = '0;
              hcnt_d  = '0;
              level_d = 1'b0;
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
              hcnt_d = hcnt_step;
              hold_d = hold_fire;
            end
          end
          default: begin
            cnt_d   = '0;
            hcnt_d  = '0;
            level_d = 1'b0;
          end
        endcase
      end
    end

    assign o_level[g] = level_q;
    assign o_press[g] = press_q;
    assign o_hold[g]  = hold_q;
  end

endmodule

// File: tb/tb_button_conditioner_ice.sv
// tb/tb_button_conditioner_ice.sv - self-checking bench for button_conditioner_ice
module tb_button_conditioner_ice;

  localparam int DEB  = 4;
  localparam int HOLD = 16;

  logic       clk = 1'b0;
  logic       res;
  logic       ena;
  logic [2:0] buttons;
  logic [2:0] o_level;
  logic [2:0] o_press;
  logic [2:0] o_hold;

  int checks = 0;
  int errors = 0;

  button_conditioner_ice #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (14),
    .HOLD_W         (20)
  ) dut (
    .clk_in   (clk),
    .res      (res),
    .ena      (ena),
    .i_buttons(buttons),
    .o_level  (o_level),
    .o_press  (o_press),
    .o_hold   (o_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a level flips once the synchronised input has disagreed
  // with it for DEB consecutive enabled samples; hold fires when the accepted
  // high level reaches an age of HOLD enabled edges.
  bit       s1m [3];
  bit       s2m [3];
  bit       lvl [3];
  int       run [3];
  int       age [3];
  bit [2:0] exp_level = '0;
  bit [2:0] exp_press = '0;
  bit [2:0] exp_hold  = '0;

  always @(posedge clk or posedge res) begin
    if (res) begin
      for (int ch = 0; ch < 3; ch++) begin
        s1m[ch] = 1'b0; s2m[ch] = 1'b0; lvl[ch] = 1'b0; run[ch] = 0; age[ch] = 0;
      end
      exp_press = '0;
      exp_hold  = '0;
    end else begin
      exp_press = '0;
      exp_hold  = '0;
      for (int ch = 0; ch < 3; ch++) begin
        if (ena) begin
          if (s2m[ch] != lvl[ch]) run[ch]++;
          else                    run[ch] = 0;
          if (run[ch] == DEB) begin
            lvl[ch] = ~lvl[ch];
            run[ch] = 0;
            if (lvl[ch]) begin
              exp_press[ch] = 1'b1;
              age[ch] = 0;
            end
          end else if (lvl[ch] && age[ch] < HOLD) begin
            age[ch]++;
            if (age[ch] == HOLD) exp_hold[ch] = 1'b1;
          end
        end
        s2m[ch] = s1m[ch];
        s1m[ch] = buttons[ch];
      end
    end
    for (int ch = 0; ch < 3; ch++) exp_level[ch] = lvl[ch];
  end

  // Every-cycle comparison against the model, away from the clock edges.
  always @(posedge clk) begin
    #2;
    chk("model_level", o_level, exp_level);
    chk("model_press", o_press, exp_press);
    chk("model_hold",  o_hold,  exp_hold);
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    res     = 1'b1;
    ena     = 1'b1;
    buttons = 3'b000;
    wait_n(2);
    chk("reset_level", o_level, 3'b000);
    chk("reset_press", o_press, 3'b000);
    chk("reset_hold",  o_hold,  3'b000);
    res = 1'b0;
    wait_n(3);

    // Clean press on bit 0, held; level after E5, hold 16 edges later.
    buttons = 3'b001;
    wait_n(5);
    chk("press0_before", o_level, 3'b000);
    wait_n(1);
    chk("press0_level", o_level, 3'b001);
    chk("press0_pulse", o_press, 3'b001);
    wait_n(1);
    chk("press0_once", o_press, 3'b000);
    wait_n(14);
    chk("hold0_before", o_hold, 3'b000);
    wait_n(1);
    chk("hold0_fire", o_hold, 3'b001);
    wait_n(1);
    chk("hold0_once", o_hold, 3'b000);
    wait_n(18);

    // Release glitch of 2 cycles keeps the level; steady low drops it after E5.
    buttons = 3'b000;
    wait_n(2);
    buttons = 3'b001;
    for (int i = 0; i < 8; i++) begin
      wait_n(1);
      chk("relglitch_level", o_level, 3'b001);
      chk("relglitch_press", o_press, 3'b000);
    end
    buttons = 3'b000;
    wait_n(5);
    chk("release_before", o_level, 3'b001);
    wait_n(1);
    chk("release_level", o_level, 3'b000);
    wait_n(4);

    // Bounce on bit 1: 1-, 2-, 3-cycle glitches, then steady high.
    for (int g = 1; g <= 3; g++) begin
      buttons = 3'b010;
      wait_n(g);
      buttons = 3'b000;
      for (int i = 0; i < 3; i++) begin
        wait_n(1);
        chk("bounce_press", o_press, 3'b000);
        chk("bounce_level", o_level, 3'b000);
      end
    end
    wait_n(3);
    buttons = 3'b010;
    wait_n(5);
    chk("bounce_steady_before", o_press, 3'b000);
    wait_n(1);
    chk("bounce_steady_press", o_press, 3'b010);
    buttons = 3'b000;
    wait_n(8);

    // Simultaneous press of all three channels.
    buttons = 3'b111;
    wait_n(6);
    chk("all_press", o_press, 3'b111);
    chk("all_level", o_level, 3'b111);
    buttons = 3'b000;
    wait_n(8);

    // ena low during RISE_CHK on bit 2 freezes it; press completes after the remaining count.
    buttons = 3'b100;
    wait_n(3);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_n(1);
      chk("ena_off_press", o_press, 3'b000);
      chk("ena_off_level", o_level, 3'b000);
    end
    ena = 1'b1;
    wait_n(2);
    chk("ena_resume_before", o_press, 3'b000);
    wait_n(1);
    chk("ena_resume_press", o_press, 3'b100);
    chk("ena_resume_level", o_level, 3'b100);
    wait_n(4);

    // Asynchronous reset while bit 2 is high and held; fresh press after release.
    res = 1'b1;
    #1;
    chk("async_res_level", o_level, 3'b000);
    chk("async_res_press", o_press, 3'b000);
    wait_n(3);
    res = 1'b0;
    wait_n(5);
    chk("post_res_before", o_press, 3'b000);
    wait_n(1);
    chk("post_res_press", o_press, 3'b100);
    chk("post_res_level", o_level, 3'b100);
    buttons = 3'b000;
    wait_n(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
